// File: rtl/serial_sub_pkg.sv
// ============================================================================
// Module      : serial_sub_pkg
// Description : Shared FSM state encoding for the bit-serial subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/full_subtractor_cell.sv
// ============================================================================
// Module      : full_subtractor_cell
// Description : Combinational full subtractor (a - b - bin) from two
//               half-subtractor stages whose borrows are ORed.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_subtractor_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic w_d1;
    logic w_b1;
    logic w_b2;

    assign w_d1 = a ^ b;
    assign w_b1 = ~a & b;
    assign d    = w_d1 ^ bin;
    assign w_b2 = ~w_d1 & bin;
    assign bout = w_b1 | w_b2;

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial WIDTH-bit subtractor d = a - b, LSB first, with a
//               start/ready/done handshake. Define SERIAL_SUB_SAT_EN to clamp
//               the result to zero whenever the final borrow is set.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             br
);

    localparam int              CNT_W        = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] c_last_count = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sa_q, sa_d;
    logic [WIDTH-1:0]   sb_q, sb_d;
    // Only WIDTH-1 result bits are stored; the last bit is merged straight into d.
    logic [WIDTH-2:0]   res_q, res_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               borrow_q, borrow_d;
    logic [WIDTH-1:0]   d_q, d_d;
    logic               br_q, br_d;

    logic               w_bit;
    logic               w_bout;
    logic [WIDTH-1:0]   w_shift;

    full_subtractor_cell u_cell (
        .a    (sa_q[0]),
        .b    (sb_q[0]),
        .bin  (borrow_q),
        .d    (w_bit),
        .bout (w_bout)
    );

    assign w_shift = {w_bit, res_q};

    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        d_d      = d_q;
        br_d     = br_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sa_d     = a;
                    sb_d     = b;
                    res_d    = '0;
                    cnt_d    = '0;
                    borrow_d = 1'b0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                sa_d     = {1'b0, sa_q[WIDTH-1:1]};
                sb_d     = {1'b0, sb_q[WIDTH-1:1]};
                res_d    = w_shift[WIDTH-1:1];
                borrow_d = w_bout;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == c_last_count) begin
`ifdef SERIAL_SUB_SAT_EN
                    d_d = w_bout ? '0 : w_shift;
`else
                    d_d = w_shift;
`endif
                    br_d    = w_bout;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            d_q      <= '0;
            br_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            d_q      <= d_d;
            br_q     <= br_d;
        end
    end

    assign ready = (state_q == IDLE);
    assign done  = (state_q == DONE);
    assign d     = d_q;
    assign br    = br_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Self-checking bench for serial_subtractor (WIDTH=8), directed
//               and random operations against an arithmetic reference model.
//               Honours SERIAL_SUB_SAT_EN when computing expected results.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             br;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [WIDTH-1:0] exp_d  = '0;
    logic             exp_br = 1'b0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .ready (ready),
        .done  (done),
        .d     (d),
        .br    (br)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: integer difference, borrow when negative, optional clamp.
    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        int               diff;
        logic             m_br;
        logic [WIDTH-1:0] m_d;
        diff = int'(x) - int'(y);
        m_br = (diff < 0);
        m_d  = WIDTH'((diff + (1 << WIDTH)) % (1 << WIDTH));
`ifdef SERIAL_SUB_SAT_EN
        if (m_br) m_d = '0;
`endif
        return {m_br, m_d};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                          input int inject, input string tag);
        logic [WIDTH:0] m;
        int             n;
        int             rlow;
        bit             hold_ok;
        m       = model(x, y);
        n       = 0;
        rlow    = 0;
        hold_ok = 1'b1;
        for (int i = 0; i < 30 && ready !== 1'b1; i++) step();
        a     = x;
        b     = y;
        start = 1'b1;
        step();
        start = 1'b0;
        while (done !== 1'b1 && n < 30) begin
            if (ready === 1'b0) rlow++;
            if (d !== exp_d || br !== exp_br) hold_ok = 1'b0;
            if (n == inject) begin
                start = 1'b1;
                a     = 8'h01;
                b     = 8'h02;
            end else begin
                start = 1'b0;
                a     = WIDTH'($urandom);
                b     = WIDTH'($urandom);
            end
            step();
            n++;
        end
        start = 1'b0;
        if (ready === 1'b0) rlow++;
        check({tag, " latency"}, n, WIDTH);
        check({tag, " ready_low"}, rlow, WIDTH + 1);
        check({tag, " hold"}, {31'd0, hold_ok}, 32'd1);
        check({tag, " d"}, {24'd0, d}, {24'd0, m[WIDTH-1:0]});
        check({tag, " br"}, {31'd0, br}, {31'd0, m[WIDTH]});
        exp_d  = m[WIDTH-1:0];
        exp_br = m[WIDTH];
        step();
        check({tag, " done_ready_after"}, {30'd0, done, ready}, 32'd1);
    endtask

    initial begin
        logic [WIDTH:0] m;
        int             c1;
        int             c2;
        int             k;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        step();
        check("reset outputs", {21'd0, ready, done, br, d}, {21'd0, 1'b1, 1'b0, 1'b0, 8'h00});
        rst = 1'b0;
        step();

        run_op(8'h5A, 8'h23, -1, "5A-23");
        run_op(8'h10, 8'h20, -1, "10-20");
        run_op(8'hFF, 8'hFF, -1, "FF-FF");
        run_op(8'h00, 8'h01, -1, "00-01");
        run_op(8'h5A, 8'h23, 2, "ignored_start");

        // Asynchronous reset partway through an operation.
        a     = 8'h5A;
        b     = 8'h23;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        #2 rst = 1'b1;
        #1;
        check("async reset", {21'd0, ready, done, br, d}, {21'd0, 1'b1, 1'b0, 1'b0, 8'h00});
        #2 rst = 1'b0;
        exp_d  = '0;
        exp_br = 1'b0;
        step();
        run_op(8'h80, 8'h01, -1, "80-01");

        // Back-to-back ops with start held high.
        a     = 8'h09;
        b     = 8'h04;
        start = 1'b1;
        step();
        k = 0;
        while (done !== 1'b1 && k < 30) begin step(); k++; end
        c1 = cyc;
        m  = model(8'h09, 8'h04);
        check("held op1 d/br", {23'd0, br, d}, {23'd0, m});
        a = 8'h04;
        b = 8'h09;
        step();
        k = 0;
        while (done !== 1'b1 && k < 30) begin step(); k++; end
        c2 = cyc;
        start = 1'b0;
        m  = model(8'h04, 8'h09);
        check("held op2 d/br", {23'd0, br, d}, {23'd0, m});
        check("held spacing", c2 - c1, WIDTH + 2);
        exp_d  = m[WIDTH-1:0];
        exp_br = m[WIDTH];
        step();

        for (int i = 0; i < 16; i++) begin
            run_op(WIDTH'($urandom), WIDTH'($urandom), -1, "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
